// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default datapath width and
// status-register bit positions.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;
    localparam int STAT_W = 3;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Shared adder for ADD and SUB. Signed-overflow detection exists only when
// ALU_OVF_EN is defined; otherwise ovf_o is tied low.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction as A + ~B + 1 so one carry chain serves both operations.
    assign b_eff = sub_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + WIDTH'(sub_i);

`ifdef ALU_OVF_EN
    // Operands of equal sign (after inversion for SUB) yielding a result of
    // the other sign overflowed.
    assign ovf_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
`else
    assign ovf_o = 1'b0;
`endif

endmodule : alu_addsub

// File: rtl/alu.sv
// Combinational ALU (ADD/SUB/AND/NOT) with a loadable {V,N,Z} status register.
// V is only computed when ALU_OVF_EN is defined; otherwise status[2] stays 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  Ain,
    input  logic [WIDTH-1:0]  Bin,
    input  logic [1:0]        ALUop,
    input  logic              load_status,
    output logic [WIDTH-1:0]  out,
    output logic              Z,
    output logic [STAT_W-1:0] status
);

    logic [WIDTH-1:0]  sum;
    logic              ovf;
    logic              is_arith;
    logic [WIDTH-1:0]  result;
    logic [STAT_W-1:0] flags;
    logic [STAT_W-1:0] status_d;
    logic [STAT_W-1:0] status_q;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i   (Ain),
        .b_i   (Bin),
        .sub_i (ALUop == ALU_SUB),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    assign is_arith = (ALUop == ALU_ADD) || (ALUop == ALU_SUB);

    always_comb begin
        result = '0;
        case (alu_op_e'(ALUop))
            ALU_ADD: result = sum;
            ALU_SUB: result = sum;
            ALU_AND: result = Ain & Bin;
            ALU_NOT: result = ~Bin;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[STAT_Z] = (result == '0);
        flags[STAT_N] = result[WIDTH-1];
        flags[STAT_V] = is_arith & ovf;
    end

    assign status_d = load_status ? flags : status_q;

    // Reset is synchronous and wins over load_status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign out    = result;
    assign Z      = flags[STAT_Z];
    assign status = status_q;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [1:0]  aluop;
    logic        load_status;
    logic [15:0] dut_out;
    logic        dut_z;
    logic [2:0]  dut_status;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_status;

    alu #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ain         (ain),
        .Bin         (bin),
        .ALUop       (aluop),
        .load_status (load_status),
        .out         (dut_out),
        .Z           (dut_z),
        .status      (dut_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    function automatic int ref_out(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 65536;
            1:       return (a - b + 65536) % 65536;
            2:       return a & b;
            default: return 65535 - b;
        endcase
    endfunction

    function automatic bit ref_v(input int a, input int b, input int op);
        int r;
        if (op == 0)      r = to_signed(a) + to_signed(b);
        else if (op == 1) r = to_signed(a) - to_signed(b);
        else              return 1'b0;
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation, check combinational outputs, clock it, check status.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic ld, input logic rn, input string tag);
        int  eo;
        bit  ez, en, ev;
        ain = a; bin = b; aluop = op; load_status = ld; rst_n = rn;
        #1;
        eo = ref_out(int'(a), int'(b), int'(op));
        ez = (eo == 0);
        en = (eo >= 32768);
`ifdef ALU_OVF_EN
        ev = ref_v(int'(a), int'(b), int'(op));
`else
        ev = 1'b0;
`endif
        chk({tag, ".out"}, 32'(dut_out), 32'(eo));
        chk({tag, ".Z"}, 32'(dut_z), 32'(ez));
        if (!rn)     exp_status = 3'b000;
        else if (ld) exp_status = {ev, en, ez};
        @(posedge clk);
        #1;
        chk({tag, ".status"}, 32'(dut_status), 32'(exp_status));
    endtask

    initial begin
        exp_status  = 3'b000;
        ain = '0; bin = '0; aluop = 2'b00; load_status = 1'b1; rst_n = 1'b0;
        @(negedge clk);

        step(16'h1234, 16'h0001, 2'b00, 1'b1, 1'b0, "reset");
        chk("reset_status", 32'(dut_status), 32'h0);

        step(16'h000D, 16'h0006, 2'b00, 1'b1, 1'b1, "add");
        chk("add_const", 32'(dut_out), 32'h0013);
        step(16'h000D, 16'h0006, 2'b01, 1'b1, 1'b1, "sub");
        chk("sub_const", 32'(dut_out), 32'h0007);
        step(16'h0006, 16'h000D, 2'b01, 1'b1, 1'b1, "sub_neg");
        chk("sub_neg_out", 32'(dut_out), 32'hFFF9);
        chk("sub_neg_N", 32'(dut_status[1]), 32'h1);
        step(16'h000D, 16'h0006, 2'b10, 1'b1, 1'b1, "and");
        chk("and_const", 32'(dut_out), 32'h0004);
        step(16'h000D, 16'h0006, 2'b11, 1'b1, 1'b1, "not");
        chk("not_const", 32'(dut_out), 32'hFFF9);
        step(16'h000D, 16'hFFFF, 2'b11, 1'b1, 1'b1, "not_zero");
        chk("not_zero_Z", 32'(dut_z), 32'h1);

        step(16'h7FFF, 16'h0001, 2'b00, 1'b1, 1'b1, "ovf_add");
        chk("ovf_out", 32'(dut_out), 32'h8000);
`ifdef ALU_OVF_EN
        chk("ovf_status", 32'(dut_status), 32'h6);
`else
        chk("ovf_status", 32'(dut_status), 32'h2);
`endif
        step(16'h8000, 16'h0001, 2'b01, 1'b1, 1'b1, "ovf_sub");

        step(16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1, "load_zero");
        chk("load_zero_status", 32'(dut_status), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, 1'b1, "hold");
        end
        chk("hold_status", 32'(dut_status), 32'h1);
        step(16'h0055, 16'h0022, 2'b00, 1'b1, 1'b0, "reset_prio");
        chk("reset_prio_status", 32'(dut_status), 32'h0);
        chk("reset_out_tracks", 32'(dut_out), 32'h0077);

        for (int i = 0; i < 300; i++) begin
            step(16'($urandom), 16'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 15) != 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, datapath width in bits; all values below assume 16.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for the status register.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: Ain  input  WIDTH  operand A.
REQ-005 SHALL have port: Bin  input  WIDTH  operand B.
REQ-006 SHALL have port: ALUop  input  2  operation select.
REQ-007 SHALL have port: load_status  input  1  capture the current flags into the status register on the next clk edge.
REQ-008 SHALL have port: out  output  WIDTH  combinational result.
REQ-009 SHALL have port: Z  output  1  combinational zero flag of out.
REQ-010 SHALL have port: status  output  3  registered flags {V,N,Z}, bit 0 = Z.

Function
REQ-011 SHALL, for ALUop 2'b00, drive out = Ain + Bin modulo 2^WIDTH, with carry discarded.
REQ-012 SHALL, for ALUop 2'b01, drive out = Ain - Bin modulo 2^WIDTH (two's complement), with borrow discarded.
REQ-013 SHALL, for ALUop 2'b10, drive out = Ain & Bin bitwise.
REQ-014 SHALL, for ALUop 2'b11, drive out = ~Bin bitwise; Ain is ignored.
REQ-015 SHALL make out and Z purely combinational, with zero clock latency; a change on any input is reflected without waiting for clk.
REQ-016 SHALL drive Z = 1 exactly when out == 0, else 0.
REQ-017 SHALL compute N = out[WIDTH-1].
REQ-018 SHALL compute V (signed overflow) as follows:
- ADD: set when Ain and Bin have the same sign and out's sign differs.
- SUB: set when Ain and Bin have different signs and out's sign differs from Ain's.
- AND and NOT: V = 0.
REQ-019 SHALL, on a rising clk edge with rst_n=1 and load_status=1, load status <= {V,N,Z} of the current inputs; with load_status=0, status holds.
REQ-020 SHALL give no clock cycle an undefined output; X/Z on inputs is not required to be handled.

Reset
REQ-021 SHALL, on a rising clk edge with rst_n=0, clear status to 3'b000 regardless of load_status; reset has priority.
REQ-022 SHALL leave out and Z unaffected by rst_n; they always reflect the inputs, including during reset.

Configuration
REQ-023 SHALL, when macro ALU_OVF_EN is defined, compute V per REQ-018 and load it into status[2].
REQ-024 SHALL, when ALU_OVF_EN is undefined, omit the overflow logic; status[2] is then constant 0, and N and Z behave identically in both builds.

Structure
REQ-025 SHALL place the following in shared package alu_pkg:
- the ALUop encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_NOT=2'b11;
- the default WIDTH constant;
- the status bit index constants.
REQ-026 SHALL implement the add/subtract path in one sub-module, alu_addsub (operands, sub select, sum, and signed-overflow output); the AND/NOT logic, flag logic and status register stay in alu.

Verification
REQ-027 SHALL cover ADD: Ain=0x000D, Bin=0x0006, ALUop=00 -> out=0x0013, Z=0.
REQ-028 SHALL cover SUB: Ain=0x000D, Bin=0x0006, ALUop=01 -> out=0x0007, Z=0; and Ain=0x0006, Bin=0x000D -> out=0xFFF9, N=1 when loaded.
REQ-029 SHALL cover AND and NOT: Ain=0x000D, Bin=0x0006:
- ALUop=10 -> out=0x0004.
- ALUop=11 -> out=0xFFF9.
- ALUop=11 with Bin=0xFFFF -> out=0x0000, Z=1.
REQ-030 SHALL cover overflow with ALU_OVF_EN defined: Ain=0x7FFF, Bin=0x0001, ALUop=00, load_status=1, one clk -> out=0x8000 and status=3'b110; without the macro -> status=3'b010.
REQ-031 SHALL cover status register control:
- Load status=3'b001 with a zero result.
- Then hold load_status=0 while changing inputs for 3 clks -> status unchanged.
- Then assert rst_n=0 with load_status=1 for one clk -> status=3'b000 while out still tracks the inputs.
